// File: rtl/image_mem_pkg.sv
// Shared types for the image memory arbiter: address widths, read owner and pixel address.
package image_mem_pkg;

    localparam int unsigned XBits = 9;
    localparam int unsigned YBits = 8;

    // Who the read issued last cycle belongs to.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_DISP = 2'd1,
        OWN_CPU  = 2'd2
    } owner_t;

    typedef struct packed {
        logic [XBits-1:0] x;
        logic [YBits-1:0] y;
    } pix_addr_t;

    localparam pix_addr_t PixAddrZero = '{x: '0, y: '0};

    function automatic logic addr_eq(input pix_addr_t a, input pix_addr_t b);
        return (a.x == b.x) && (a.y == b.y);
    endfunction

endpackage

// File: rtl/image_mem_arbiter_if.sv
// Requester handshakes plus the image memory ports, bundled for the arbiter.
interface image_mem_arbiter_if #(
    parameter int unsigned ColorBits = 3
);
    import image_mem_pkg::*;

    // Display scanout reads
    logic                 disp_req;
    logic [XBits-1:0]     disp_x;
    logic [YBits-1:0]     disp_y;
    logic                 disp_gnt;
    logic                 disp_valid;
    logic [ColorBits-1:0] disp_data;

    // Processor loads
    logic                 cpu_rd_req;
    logic [XBits-1:0]     cpu_rd_x;
    logic [YBits-1:0]     cpu_rd_y;
    logic                 cpu_rd_gnt;
    logic                 cpu_rd_valid;
    logic [ColorBits-1:0] cpu_rd_data;

    // Processor stores
    logic                 cpu_wr_req;
    logic [XBits-1:0]     cpu_wr_x;
    logic [YBits-1:0]     cpu_wr_y;
    logic [ColorBits-1:0] cpu_wr_data;
    logic                 cpu_wr_gnt;

    // Image memory ports
    logic [XBits-1:0]     mem_x_read;
    logic [YBits-1:0]     mem_y_read;
    logic [ColorBits-1:0] mem_read_value;
    logic [XBits-1:0]     mem_x_write;
    logic [YBits-1:0]     mem_y_write;
    logic [ColorBits-1:0] mem_write_value;

    // Arbiter side
    modport slave (
        input  disp_req, disp_x, disp_y,
        output disp_gnt, disp_valid, disp_data,
        input  cpu_rd_req, cpu_rd_x, cpu_rd_y,
        output cpu_rd_gnt, cpu_rd_valid, cpu_rd_data,
        input  cpu_wr_req, cpu_wr_x, cpu_wr_y, cpu_wr_data,
        output cpu_wr_gnt,
        output mem_x_read, mem_y_read,
        input  mem_read_value,
        output mem_x_write, mem_y_write, mem_write_value
    );

    // Requester and memory side
    modport master (
        output disp_req, disp_x, disp_y,
        input  disp_gnt, disp_valid, disp_data,
        output cpu_rd_req, cpu_rd_x, cpu_rd_y,
        input  cpu_rd_gnt, cpu_rd_valid, cpu_rd_data,
        output cpu_wr_req, cpu_wr_x, cpu_wr_y, cpu_wr_data,
        input  cpu_wr_gnt,
        input  mem_x_read, mem_y_read,
        output mem_read_value,
        input  mem_x_write, mem_y_write, mem_write_value
    );

endinterface

// File: rtl/image_mem_arbiter_read_arbiter.sv
// Read-port arbiter: display has priority, a CPU load is forced through after CpuMaxWait losses.
module read_arbiter
    import image_mem_pkg::*;
#(
    parameter int unsigned CpuMaxWait = 4
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   disp_req_i,
    input  logic   cpu_req_i,
    output logic   disp_gnt_o,
    output logic   cpu_gnt_o,
    output owner_t owner_o
);

    localparam int unsigned CntBits = (CpuMaxWait > 0) ? $clog2(CpuMaxWait + 1) : 1;
    localparam logic [CntBits-1:0] MaxWait = CntBits'(CpuMaxWait);

    logic [CntBits-1:0] wait_cnt_q, wait_cnt_d;
    logic               cpu_starved;

    assign cpu_starved = (wait_cnt_q == MaxWait);

    // Grant decode: at most one read per cycle.
    always_comb begin
        cpu_gnt_o  = cpu_req_i && (!disp_req_i || cpu_starved);
        disp_gnt_o = disp_req_i && !cpu_gnt_o;
        owner_o    = OWN_NONE;
        if (disp_gnt_o) begin
            owner_o = OWN_DISP;
        end else if (cpu_gnt_o) begin
            owner_o = OWN_CPU;
        end
    end

    // Starvation counter: counts lost cycles of a pending load, saturating.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!cpu_req_i || cpu_gnt_o) begin
            wait_cnt_d = '0;
        end else if (!cpu_starved) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    // Counter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

endmodule

// File: rtl/image_mem_arbiter.sv
// Front end of the single-read/single-write image memory: read arbitration, write-first
// forwarding and an always-idempotent write port.
module image_mem_arbiter
    import image_mem_pkg::*;
#(
    parameter int unsigned          Width      = 50,
    parameter int unsigned          Height     = 50,
    parameter int unsigned          ColorBits  = 3,
    parameter logic [ColorBits-1:0] InitColor  = 3'b001,
    parameter int unsigned          CpuMaxWait = 4
) (
    input logic                clk,
    input logic                rst_n,
    image_mem_arbiter_if.slave bus_io
);

    typedef logic [ColorBits-1:0] color_t;

    logic      disp_req, cpu_rd_req, cpu_wr_req;
    logic      disp_gnt, cpu_rd_gnt, rd_gnt;
    owner_t    owner_d, owner_q;
    pix_addr_t disp_addr, cpu_rd_addr, cpu_wr_addr;
    pix_addr_t rd_addr_d, rd_addr_q;
    pix_addr_t wr_addr, last_wr_addr_q, fwd_addr_q;
    color_t    wr_data, last_wr_data_q, fwd_data_q, rd_data;
    logic      fwd_hit, cpu_wr_gnt;

    // Requests are ignored while reset is held so grants stay low and the write port
    // shows the reset repeat-write of (0,0,InitColor).
    assign disp_req   = bus_io.disp_req & rst_n;
    assign cpu_rd_req = bus_io.cpu_rd_req & rst_n;
    assign cpu_wr_req = bus_io.cpu_wr_req & rst_n;

    assign disp_addr   = '{x: bus_io.disp_x,   y: bus_io.disp_y};
    assign cpu_rd_addr = '{x: bus_io.cpu_rd_x, y: bus_io.cpu_rd_y};
    assign cpu_wr_addr = '{x: bus_io.cpu_wr_x, y: bus_io.cpu_wr_y};

    read_arbiter #(
        .CpuMaxWait (CpuMaxWait)
    ) u_read_arbiter (
        .clk        (clk),
        .rst_n      (rst_n),
        .disp_req_i (disp_req),
        .cpu_req_i  (cpu_rd_req),
        .disp_gnt_o (disp_gnt),
        .cpu_gnt_o  (cpu_rd_gnt),
        .owner_o    (owner_d)
    );

    assign rd_gnt = disp_gnt | cpu_rd_gnt;

    // Read address: the granted requester this cycle, otherwise hold the last issued one.
    always_comb begin
        rd_addr_d = rd_addr_q;
        if (disp_gnt) begin
            rd_addr_d = disp_addr;
        end else if (cpu_rd_gnt) begin
            rd_addr_d = cpu_rd_addr;
        end
    end

    // The memory returns old data when its write port hit the same address in the grant
    // cycle, so the value written then is substituted.
    assign fwd_hit = addr_eq(rd_addr_q, fwd_addr_q);
    assign rd_data = fwd_hit ? fwd_data_q : bus_io.mem_read_value;

    // Write source: store, else refresh of last cycle's read, else repeat of the last write.
    always_comb begin
        cpu_wr_gnt = 1'b0;
        wr_addr    = last_wr_addr_q;
        wr_data    = last_wr_data_q;
        if (cpu_wr_req) begin
            cpu_wr_gnt = 1'b1;
            wr_addr    = cpu_wr_addr;
            wr_data    = bus_io.cpu_wr_data;
        end else if (owner_q != OWN_NONE) begin
            wr_addr = rd_addr_q;
            wr_data = rd_data;
        end
    end

    // Issued-read bookkeeping: owner, address and the write it raced with.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q    <= OWN_NONE;
            rd_addr_q  <= PixAddrZero;
            fwd_addr_q <= PixAddrZero;
            fwd_data_q <= '0;
        end else begin
            owner_q <= owner_d;
            if (rd_gnt) begin
                rd_addr_q  <= rd_addr_d;
                fwd_addr_q <= wr_addr;
                fwd_data_q <= wr_data;
            end
        end
    end

    // Every committed write becomes the repeat candidate for idle cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_wr_addr_q <= PixAddrZero;
            last_wr_data_q <= InitColor;
        end else begin
            last_wr_addr_q <= wr_addr;
            last_wr_data_q <= wr_data;
        end
    end

    assign bus_io.disp_gnt     = disp_gnt;
    assign bus_io.cpu_rd_gnt   = cpu_rd_gnt;
    assign bus_io.cpu_wr_gnt   = cpu_wr_gnt;
    assign bus_io.disp_valid   = (owner_q == OWN_DISP);
    assign bus_io.cpu_rd_valid = (owner_q == OWN_CPU);
    assign bus_io.disp_data    = (owner_q == OWN_DISP) ? rd_data : '0;
    assign bus_io.cpu_rd_data  = (owner_q == OWN_CPU) ? rd_data : '0;

    assign bus_io.mem_x_read      = rd_addr_d.x;
    assign bus_io.mem_y_read      = rd_addr_d.y;
    assign bus_io.mem_x_write     = wr_addr.x;
    assign bus_io.mem_y_write     = wr_addr.y;
    assign bus_io.mem_write_value = wr_data;

    // Requesters own address range; these only flag a broken requester in simulation.
    a_disp_range : assert property (@(posedge clk) disable iff (!rst_n)
        bus_io.disp_req |-> (32'(bus_io.disp_x) < Width && 32'(bus_io.disp_y) < Height));
    a_cpu_rd_range : assert property (@(posedge clk) disable iff (!rst_n)
        bus_io.cpu_rd_req |-> (32'(bus_io.cpu_rd_x) < Width && 32'(bus_io.cpu_rd_y) < Height));
    a_cpu_wr_range : assert property (@(posedge clk) disable iff (!rst_n)
        bus_io.cpu_wr_req |-> (32'(bus_io.cpu_wr_x) < Width && 32'(bus_io.cpu_wr_y) < Height));

endmodule

// File: tb/tb_image_mem_arbiter.sv
// Directed bench for image_mem_arbiter with an image memory model and read-data scoreboard.
module tb_image_mem_arbiter;
    import image_mem_pkg::*;

    localparam int unsigned          Width      = 50;
    localparam int unsigned          Height     = 50;
    localparam int unsigned          ColorBits  = 3;
    localparam logic [ColorBits-1:0] InitColor  = 3'b001;
    localparam int unsigned          CpuMaxWait = 4;
    localparam int                   NPix       = int'(Width * Height);

    logic clk       = 1'b0;
    logic rst_n     = 1'b0;
    logic mem_clear = 1'b1;
    int   total     = 0;
    int   bad       = 0;

    always #5 clk = ~clk;

    image_mem_arbiter_if #(.ColorBits(ColorBits)) bus_if ();

    image_mem_arbiter #(
        .Width      (Width),
        .Height     (Height),
        .ColorBits  (ColorBits),
        .InitColor  (InitColor),
        .CpuMaxWait (CpuMaxWait)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus_if)
    );

    function automatic int idx(input int x, input int y);
        return y * int'(Width) + x;
    endfunction

    // Image memory: registered read with old data on a same-address write.
    logic [ColorBits-1:0] mem [NPix];
    logic [ColorBits-1:0] mem_rd_q;
    assign bus_if.mem_read_value = mem_rd_q;

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < NPix; i++) mem[i] <= InitColor;
        end else begin
            mem_rd_q <= mem[idx(int'(bus_if.mem_x_read), int'(bus_if.mem_y_read))];
            mem[idx(int'(bus_if.mem_x_write), int'(bus_if.mem_y_write))] <= bus_if.mem_write_value;
        end
    end

    // Expected image and read-return scoreboard.
    logic [ColorBits-1:0] exp_img [NPix];
    logic [ColorBits-1:0] disp_sb[$];
    logic [ColorBits-1:0] cpu_sb[$];
    logic disp_due_now = 1'b0, disp_due_next = 1'b0;
    logic cpu_due_now  = 1'b0, cpu_due_next  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_wr(input string tag, input int x, input int y, input int v);
        chk({tag, "_x"}, 32'(bus_if.mem_x_write), 32'(x));
        chk({tag, "_y"}, 32'(bus_if.mem_y_write), 32'(y));
        chk({tag, "_v"}, 32'(bus_if.mem_write_value), 32'(v));
    endtask

    // Write-first view of a pixel in the current cycle.
    function automatic logic [ColorBits-1:0] pix_now(input int x, input int y);
        if (bus_if.cpu_wr_req && int'(bus_if.cpu_wr_x) == x && int'(bus_if.cpu_wr_y) == y)
            return bus_if.cpu_wr_data;
        return exp_img[idx(x, y)];
    endfunction

    // Mid-cycle sample: return-path checks against the scoreboard.
    task automatic neg();
        @(negedge clk);
        chk("disp_valid", 32'(bus_if.disp_valid), 32'(disp_due_now));
        chk("cpu_rd_valid", 32'(bus_if.cpu_rd_valid), 32'(cpu_due_now));
        if (disp_due_now) begin
            if (disp_sb.size() == 0) chk("disp_sb_empty", 32'(1), 32'(0));
            else chk("disp_data", 32'(bus_if.disp_data), 32'(disp_sb.pop_front()));
        end
        if (cpu_due_now) begin
            if (cpu_sb.size() == 0) chk("cpu_sb_empty", 32'(1), 32'(0));
            else chk("cpu_rd_data", 32'(bus_if.cpu_rd_data), 32'(cpu_sb.pop_front()));
        end
    endtask

    // Clock edge: commit stores to the expected image, advance the return schedule.
    task automatic pos();
        @(posedge clk);
        if (rst_n && bus_if.cpu_wr_req)
            exp_img[idx(int'(bus_if.cpu_wr_x), int'(bus_if.cpu_wr_y))] = bus_if.cpu_wr_data;
        #1;
        disp_due_now  = disp_due_next;
        disp_due_next = 1'b0;
        cpu_due_now   = cpu_due_next;
        cpu_due_next  = 1'b0;
    endtask

    task automatic set_disp(input logic req, input int x, input int y);
        bus_if.disp_req = req;
        bus_if.disp_x   = XBits'(x);
        bus_if.disp_y   = YBits'(y);
    endtask

    task automatic set_cpu(input logic req, input int x, input int y);
        bus_if.cpu_rd_req = req;
        bus_if.cpu_rd_x   = XBits'(x);
        bus_if.cpu_rd_y   = YBits'(y);
    endtask

    task automatic set_wr(input logic req, input int x, input int y, input int v);
        bus_if.cpu_wr_req  = req;
        bus_if.cpu_wr_x    = XBits'(x);
        bus_if.cpu_wr_y    = YBits'(y);
        bus_if.cpu_wr_data = ColorBits'(v);
    endtask

    task automatic expect_disp(input int x, input int y);
        disp_sb.push_back(pix_now(x, y));
        disp_due_next = 1'b1;
    endtask

    task automatic expect_cpu(input int x, input int y);
        cpu_sb.push_back(pix_now(x, y));
        cpu_due_next = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sx[5] = '{0, 3, 10, 1, 2};
        int sy[5] = '{0, 4, 10, 0, 0};
        int sv[5] = '{7, 2, 3, 4, 5};

        set_disp(1'b0, 0, 0);
        set_cpu(1'b0, 0, 0);
        set_wr(1'b0, 0, 0, 0);
        for (int i = 0; i < NPix; i++) exp_img[i] = InitColor;

        // Reset: requests are ignored, write port shows (0,0,InitColor)
        @(posedge clk);
        #1;
        mem_clear = 1'b0;
        set_disp(1'b1, 5, 5);
        set_wr(1'b1, 5, 5, 6);
        neg();
        chk("rst_disp_gnt", 32'(bus_if.disp_gnt), 32'(0));
        chk("rst_wr_gnt", 32'(bus_if.cpu_wr_gnt), 32'(0));
        chk("rst_disp_data", 32'(bus_if.disp_data), 32'(0));
        chk("rst_cpu_data", 32'(bus_if.cpu_rd_data), 32'(0));
        chk("rst_rd_x", 32'(bus_if.mem_x_read), 32'(0));
        chk("rst_rd_y", 32'(bus_if.mem_y_read), 32'(0));
        chk_wr("rst_wr", 0, 0, int'(InitColor));
        pos();
        set_disp(1'b0, 0, 0);
        set_wr(1'b0, 0, 0, 0);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            neg();
            chk_wr("post_rst_wr", 0, 0, int'(InitColor));
            pos();
        end

        // Seed a few pixels
        for (int i = 0; i < 5; i++) begin
            set_wr(1'b1, sx[i], sy[i], sv[i]);
            neg();
            chk("store_gnt", 32'(bus_if.cpu_wr_gnt), 32'(1));
            chk_wr("store_port", sx[i], sy[i], sv[i]);
            pos();
        end
        set_wr(1'b0, 0, 0, 0);

        // Display priority: display 4 cycles, CPU forced through on the 5th
        set_cpu(1'b1, 10, 10);
        for (int k = 1; k <= 5; k++) begin
            set_disp(1'b1, k - 1, 0);
            if (k <= 4) expect_disp(k - 1, 0);
            else expect_cpu(10, 10);
            neg();
            chk("prio_disp_gnt", 32'(bus_if.disp_gnt), 32'(k <= 4));
            chk("prio_cpu_gnt", 32'(bus_if.cpu_rd_gnt), 32'(k == 5));
            pos();
        end
        set_disp(1'b0, 0, 0);
        set_cpu(1'b0, 0, 0);
        neg();
        chk("prio_wait_cnt", 32'(dut.u_read_arbiter.wait_cnt_q), 32'(0));
        pos();

        // Store then load of the same pixel in the same cycle
        set_wr(1'b1, 3, 4, 5);
        set_cpu(1'b1, 3, 4);
        expect_cpu(3, 4);
        neg();
        chk("stld_rd_gnt", 32'(bus_if.cpu_rd_gnt), 32'(1));
        chk("stld_wr_gnt", 32'(bus_if.cpu_wr_gnt), 32'(1));
        pos();
        set_wr(1'b0, 0, 0, 0);
        set_cpu(1'b0, 0, 0);
        neg();
        chk_wr("stld_refresh", 3, 4, 5);
        pos();
        neg();
        pos();
        set_cpu(1'b1, 3, 4);
        expect_cpu(3, 4);
        neg();
        chk("stld2_rd_gnt", 32'(bus_if.cpu_rd_gnt), 32'(1));
        pos();
        set_cpu(1'b0, 0, 0);

        // Display read racing a store to the same pixel: refresh must carry the store data
        set_wr(1'b1, 7, 7, 6);
        set_disp(1'b1, 7, 7);
        expect_disp(7, 7);
        neg();
        chk("fwd_disp_gnt", 32'(bus_if.disp_gnt), 32'(1));
        pos();
        set_wr(1'b0, 0, 0, 0);
        set_disp(1'b0, 0, 0);
        neg();
        chk_wr("fwd_refresh", 7, 7, 6);
        pos();

        // Idle: repeat-write of the last committed write
        for (int c = 0; c < 20; c++) begin
            neg();
            chk_wr("idle_repeat", 7, 7, 6);
            pos();
        end

        // Full display readback against the expected image
        for (int y = 0; y < int'(Height); y++) begin
            for (int x = 0; x < int'(Width); x++) begin
                set_disp(1'b1, x, y);
                expect_disp(x, y);
                neg();
                chk("rb_disp_gnt", 32'(bus_if.disp_gnt), 32'(1));
                pos();
            end
        end
        set_disp(1'b0, 0, 0);
        neg();
        pos();

        // Mid-operation reset while a CPU load is pending and a display read is in flight
        set_disp(1'b1, 1, 1);
        set_cpu(1'b1, 3, 4);
        for (int c = 0; c < 3; c++) begin
            if (c < 2) expect_disp(1, 1);
            neg();
            chk("mr_cpu_gnt", 32'(bus_if.cpu_rd_gnt), 32'(0));
            pos();
        end
        rst_n = 1'b0;
        exp_img[idx(0, 0)] = InitColor;
        neg();
        chk("mr_wait_in_rst", 32'(dut.u_read_arbiter.wait_cnt_q), 32'(0));
        chk("mr_rst_gnt", 32'(bus_if.cpu_rd_gnt), 32'(0));
        chk("mr_rst_rd_x", 32'(bus_if.mem_x_read), 32'(0));
        chk_wr("mr_rst_wr", 0, 0, int'(InitColor));
        pos();
        set_disp(1'b0, 0, 0);
        set_cpu(1'b0, 0, 0);
        neg();
        pos();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            neg();
            chk("mr_wait_after", 32'(dut.u_read_arbiter.wait_cnt_q), 32'(0));
            pos();
        end

        // Pixel (0,0) was rewritten by reset; (3,4) keeps its stored value
        set_cpu(1'b1, 0, 0);
        expect_cpu(0, 0);
        neg();
        chk("mr_ld0_gnt", 32'(bus_if.cpu_rd_gnt), 32'(1));
        pos();
        set_cpu(1'b1, 3, 4);
        expect_cpu(3, 4);
        neg();
        chk("mr_ld1_gnt", 32'(bus_if.cpu_rd_gnt), 32'(1));
        pos();
        set_cpu(1'b0, 0, 0);
        neg();
        pos();
        neg();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
